// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared ALU op codes, MIPS opcode/funct constants and ID/EX bundle
package mips_defs;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SUBU  = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_NOR   = 5'd6;
    localparam logic [4:0] OP_SLT   = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_JR    = 5'd11;
    localparam logic [4:0] OP_NOP   = 5'd12;
    localparam logic [4:0] OP_ANDI  = 5'd13;
    localparam logic [4:0] OP_ORI   = 5'd14;
    localparam logic [4:0] OP_SLTI  = 5'd15;
    localparam logic [4:0] OP_ADDI  = 5'd16;
    localparam logic [4:0] OP_ADDIU = 5'd17;
    localparam logic [4:0] OP_LW    = 5'd18;
    localparam logic [4:0] OP_SW    = 5'd19;
    localparam logic [4:0] OP_LUI   = 5'd20;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  op_code;
        logic [4:0]  shamt;
        logic [31:0] store_data;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic        mem_rd;
        logic        mem_wr;
        logic        valid;
        logic        illegal;
    } id_ex_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_file.sv
// rtl/id_ex_stage_reg_file.sv - 2R1W register file, r0 hardwired to zero, write-to-read bypass
module reg_file #(
    parameter int REG_COUNT = 32,
    parameter int AW        = $clog2(REG_COUNT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_rd_addr_a,
    output logic [31:0]   o_rd_data_a,
    input  logic [AW-1:0] i_rd_addr_b,
    output logic [31:0]   o_rd_data_b,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [31:0]   i_wr_data
);

    logic [31:0] r_regs [REG_COUNT];
    logic        w_wr_live;

    assign w_wr_live = i_wr_en && (i_wr_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // WB data forwarded so decode sees a same-cycle write without an extra stage
    assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 :
                         (w_wr_live && i_wr_addr == i_rd_addr_a) ? i_wr_data : r_regs[i_rd_addr_a];
    assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 :
                         (w_wr_live && i_wr_addr == i_rd_addr_b) ? i_wr_data : r_regs[i_rd_addr_b];

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - MIPS decode/operand fetch into the ID/EX register
module id_ex_stage
    import mips_defs::*;
#(
    parameter logic [4:0] NOP_CODE  = 5'd12,
    parameter int         REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_wr_en,
    input  logic [4:0]  wb_wr_addr,
    input  logic [31:0] wb_wr_data,
    output logic        load_use_hazard,
    output logic [31:0] ex_reg1,
    output logic [31:0] ex_reg2,
    output logic [4:0]  ex_op_code,
    output logic [4:0]  ex_shamt,
    output logic [31:0] ex_store_data,
    output logic        ex_wr_en,
    output logic [4:0]  ex_wr_addr,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic        ex_valid,
    output logic        ex_illegal
);

    logic [5:0]  w_opc;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic        w_uses_rt;
    logic        w_legal;
    logic        w_wr;
    logic [4:0]  w_dst;
    id_ex_t      w_dec;
    id_ex_t      w_bubble;
    id_ex_t      r_ex;

    assign w_opc   = id_instr[OPC_MSB:OPC_LSB];
    assign w_rs    = id_instr[RS_MSB:RS_LSB];
    assign w_rt    = id_instr[RT_MSB:RT_LSB];
    assign w_rd    = id_instr[RD_MSB:RD_LSB];
    assign w_shamt = id_instr[SH_MSB:SH_LSB];
    assign w_funct = id_instr[FN_MSB:FN_LSB];
    assign w_imm   = id_instr[IMM_MSB:IMM_LSB];

    reg_file #(.REG_COUNT(REG_COUNT), .AW(5)) u_reg_file (
        .clk         (clk),
        .rst         (rst),
        .i_rd_addr_a (w_rs),
        .o_rd_data_a (w_rs_data),
        .i_rd_addr_b (w_rt),
        .o_rd_data_b (w_rt_data),
        .i_wr_en     (wb_wr_en),
        .i_wr_addr   (wb_wr_addr),
        .i_wr_data   (wb_wr_data)
    );

    always_comb begin
        w_bubble         = '0;
        w_bubble.op_code = NOP_CODE;
    end

    always_comb begin
        w_dec            = '0;
        w_dec.op_code    = NOP_CODE;
        w_dec.valid      = 1'b1;
        w_dec.reg1       = w_rs_data;
        w_dec.store_data = w_rt_data;
        w_dec.shamt      = w_shamt;
        w_legal          = 1'b1;
        w_wr             = 1'b0;
        w_dst            = w_rt;
        if (id_instr != '0) begin
            case (w_opc)
                OPC_RTYPE: begin
                    w_dec.reg2 = w_rt_data;
                    w_dst      = w_rd;
                    w_wr       = 1'b1;
                    case (w_funct)
                        FN_ADD:  w_dec.op_code = OP_ADD;
                        FN_ADDU: w_dec.op_code = OP_ADDU;
                        FN_SUB:  w_dec.op_code = OP_SUB;
                        FN_SUBU: w_dec.op_code = OP_SUBU;
                        FN_AND:  w_dec.op_code = OP_AND;
                        FN_OR:   w_dec.op_code = OP_OR;
                        FN_NOR:  w_dec.op_code = OP_NOR;
                        FN_SLT:  w_dec.op_code = OP_SLT;
                        FN_SLL:  w_dec.op_code = OP_SLL;
                        FN_SRL:  w_dec.op_code = OP_SRL;
                        FN_SRA:  w_dec.op_code = OP_SRA;
                        FN_JR: begin
                            w_dec.op_code = OP_JR;
                            w_wr          = 1'b0;
                        end
                        default: w_legal = 1'b0;
                    endcase
                end
                OPC_ANDI:  begin w_dec.op_code = OP_ANDI;  w_dec.reg2 = zext16(w_imm); w_wr = 1'b1; end
                OPC_ORI:   begin w_dec.op_code = OP_ORI;   w_dec.reg2 = zext16(w_imm); w_wr = 1'b1; end
                OPC_SLTI:  begin w_dec.op_code = OP_SLTI;  w_dec.reg2 = sext16(w_imm); w_wr = 1'b1; end
                OPC_ADDI:  begin w_dec.op_code = OP_ADDI;  w_dec.reg2 = sext16(w_imm); w_wr = 1'b1; end
                OPC_ADDIU: begin w_dec.op_code = OP_ADDIU; w_dec.reg2 = sext16(w_imm); w_wr = 1'b1; end
                OPC_LW: begin
                    w_dec.op_code = OP_LW;
                    w_dec.reg2    = sext16(w_imm);
                    w_dec.mem_rd  = 1'b1;
                    w_wr          = 1'b1;
                end
                OPC_SW: begin
                    w_dec.op_code = OP_SW;
                    w_dec.reg2    = sext16(w_imm);
                    w_dec.mem_wr  = 1'b1;
                end
                // ALU does the shift by 16; decode only passes the raw immediate
                OPC_LUI:   begin w_dec.op_code = OP_LUI;   w_dec.reg2 = zext16(w_imm); w_wr = 1'b1; end
                default:   w_legal = 1'b0;
            endcase
        end
        if (!w_legal) begin
            w_dec.op_code = NOP_CODE;
            w_dec.illegal = 1'b1;
            w_dec.mem_rd  = 1'b0;
            w_dec.mem_wr  = 1'b0;
            w_wr          = 1'b0;
        end
        w_dec.wr_en   = w_wr;
        w_dec.wr_addr = w_wr ? w_dst : 5'd0;
    end

    assign w_uses_rt = (w_opc == OPC_RTYPE) || (w_opc == OPC_SW);

    assign load_use_hazard = r_ex.valid && r_ex.mem_rd && (r_ex.wr_addr != 5'd0) && id_valid &&
                             ((r_ex.wr_addr == w_rs) || (w_uses_rt && (r_ex.wr_addr == w_rt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex <= w_bubble;
        end else if (flush) begin
            r_ex <= w_bubble;
        end else if (stall) begin
            r_ex <= r_ex;
        end else if (load_use_hazard || !id_valid) begin
            r_ex <= w_bubble;
        end else begin
            r_ex <= w_dec;
        end
    end

    assign ex_reg1       = r_ex.reg1;
    assign ex_reg2       = r_ex.reg2;
    assign ex_op_code    = r_ex.op_code;
    assign ex_shamt      = r_ex.shamt;
    assign ex_store_data = r_ex.store_data;
    assign ex_wr_en      = r_ex.wr_en;
    assign ex_wr_addr    = r_ex.wr_addr;
    assign ex_mem_rd     = r_ex.mem_rd;
    assign ex_mem_wr     = r_ex.mem_wr;
    assign ex_valid      = r_ex.valid;
    assign ex_illegal    = r_ex.illegal;

endmodule
